mpe_result_wb: RTL
==================

# mpe_result_wb

Result writeback stage directly downstream of `matrix_pe`. It captures each 32-bit `result`/`vld_o` pulse from the PE, which has no backpressure, and packs `PACK` results into one wide word. Packed words are buffered in a small FIFO and written to the output RAM over a valid/ready port with an auto-incrementing, wrapping address. A sticky overflow flag reports any word lost while the output RAM stalls.

## Interface
- `DATA_W`, 32: width of one PE result.
- `PACK`, 4: results per output word; power of two, ≥2.
- `FIFO_DEPTH`, 8: words buffered; power of two, ≥2.
- `ADDR_W`, 8: output RAM word-address width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mpe_result`  in  DATA_W  PE result; sampled only when `mpe_vld_o`=1.
- `mpe_vld_o`  in  1  one result per cycle when high; cannot be stalled.
- `cfg_start`  in  1  pulse: begin new job.
- `cfg_base_addr`  in  ADDR_W  start address; latched on `cfg_start`.
- `flush`  in  1  pulse: emit the partially filled word.
- `wb_data`  out  PACK*DATA_W  packed word; lane i = bits [i*DATA_W +: DATA_W]; lane 0 is the first result.
- `wb_strb`  out  PACK  per-lane valid mask.
- `wb_addr`  out  ADDR_W  output RAM word address.
- `wb_valid`  out  1  word offered.
- `wb_ready`  in  1  RAM accepts; a beat transfers when `wb_valid & wb_ready`.
- `busy`  out  1  a lane is filled or the FIFO is non-empty.
- `overflow`  out  1  sticky: at least one word was dropped.
- `wb_count`  out  16  beats accepted since start; saturates at 0xFFFF.

## Operation
- **Pack register:** `PACK-1` lanes, lane counter `lane` and mask `strb_acc`. Each sampled result fills lane `lane`, and `lane` increments.
- **Word completion:** the result arriving with `lane`=PACK-1 completes the word. The word {`mpe_result`, stored lanes} with strb all-ones is pushed that same edge, and `lane` returns to 0.
- **Flush:** when `lane`≠0 after including any same-cycle result, `flush` pushes the partial word:
  - filled lanes carry data with strb bit 1;
  - unfilled lanes are zero with strb bit 0;
  - `lane` returns to 0.
  - Flush is a no-op when `lane`=0, including the case where the same-cycle result just completed a word.
- **FIFO:** circular buffer of {data, strb}, `FIFO_DEPTH` entries.
  - A push is accepted when the FIFO is not full, or when a pop occurs the same edge.
  - Otherwise the word is discarded and `overflow` is set.
  - Order is preserved.
- **Output:** `wb_valid` = FIFO non-empty. `wb_data`/`wb_strb` show the FIFO head, forced to 0 when `wb_valid`=0.
  - On each accepted beat: pop the FIFO, increment `wb_addr` (2^ADDR_W-1 wraps to 0), and increment `wb_count` (saturating).
  - `wb_data`, `wb_strb` and `wb_addr` hold stable while `wb_valid & ~wb_ready`.
- **`cfg_start`:** highest priority.
  - Empties the FIFO, clears `lane`, `strb_acc`, `overflow` and `wb_count`, and loads `wb_addr` with `cfg_base_addr`.
  - A beat handshaken in the same cycle is discarded and not counted.
  - A same-cycle `mpe_vld_o` result goes into lane 0 of the fresh job.
  - A same-cycle `flush` is ignored.

## Timing
- **Reset values:** `wb_valid`=0, `wb_data`=0, `wb_strb`=0, `wb_addr`=0, `overflow`=0, `busy`=0, `wb_count`=0. These take effect immediately on `rst` assertion, without waiting for a clock edge.
- **Latency:** if the completing result (or `flush`) is sampled at edge t, `wb_valid` is 1 after edge t, provided the FIFO was empty.
- **Throughput:** with `wb_ready` held high, one beat per cycle. The PE's maximum rate (1 result/cycle) needs one beat every PACK cycles, so no overflow is possible.
- **Simultaneous push and pop on a full FIFO:** both succeed; the FIFO stays full and `overflow` is unchanged.
- **Backpressure:** `wb_ready` may toggle arbitrarily; the block never drops `wb_valid` without a handshake, except on `cfg_start` or `rst`.
- **`busy`:** combinational from state; it drops after the edge that pops the last word while `lane`=0.
- **Reset mid-operation:** queued words and partial lanes are lost; nothing is emitted afterwards until new input arrives.

## Test plan
- **Basic pack:** `cfg_start` with base 0x10, then results 1,2,3,4 on consecutive cycles, `wb_ready`=1.
  Expect: one beat, `wb_data`=0x00000004_00000003_00000002_00000001, `wb_strb`=4'b1111, `wb_addr`=0x10; after the beat, `wb_count`=1 and `busy`=0.
- **Backpressure and overflow:** `wb_ready`=0, feed 32 results; FIFO holds 8 words and `overflow`=0. Feed 4 more: the 9th word is dropped and `overflow`=1. Raise `wb_ready`.
  Expect: 8 beats in order at addrs 0x10–0x17, then `wb_valid`=0.
- **Partial flush:** results 0xA, 0xB, then `flush`.
  Expect: `wb_strb`=4'b0011, lanes 0/1 = 0xA/0xB, lanes 2/3 = 0.
- **Flush coincident with a result:** 2 results, then the 3rd result on the same cycle as `flush`.
  Expect: `wb_strb`=4'b0111 and one beat only. Then 4 results with `flush` on the 4th.
  Expect: a single full word and no extra beat.
- **Address wrap:** base 0xFE, 12 results.
  Expect: addrs 0xFE, 0xFF, 0x00 and `wb_count`=3.
- **Reset mid-job:** 2 words queued and `wb_ready`=0; assert `rst` asynchronously between edges.
  Expect: all outputs 0 immediately and no beat after release.
  Then `cfg_start` with base 0x20 plus 4 results.
  Expect: beat at 0x20.

Source files
------------

// File: rtl/mpe_result_wb.sv
// Result writeback: packs PE results into wide words, queues them in a
// small FIFO and writes them out over valid/ready with a wrapping address.
module mpe_result_wb #(
  parameter int DATA_W     = 32,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        mpe_result,
  input  logic                     mpe_vld_o,
  input  logic                     cfg_start,
  input  logic [ADDR_W-1:0]        cfg_base_addr,
  input  logic                     flush,
  output logic [PACK*DATA_W-1:0]   wb_data,
  output logic [PACK-1:0]          wb_strb,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic                     busy,
  output logic                     overflow,
  output logic [15:0]              wb_count
);

  localparam int LW = $clog2(PACK);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int WW = PACK * DATA_W;

  logic [DATA_W-1:0] lanes [PACK-1];
  logic [LW-1:0]     lane;
  logic [PACK-2:0]   strb_acc;

  logic [LW-1:0]     lane_eff;
  logic [PACK-1:0]   strb_eff;
  logic [PACK-1:0]   hit;
  logic [PACK-1:0]   strb_new;
  logic [WW-1:0]     word;
  logic              complete;
  logic              push;

  logic [WW-1:0]     mem_data [FIFO_DEPTH];
  logic [PACK-1:0]   mem_strb [FIFO_DEPTH];
  logic [FW-1:0]     wptr;
  logic [FW-1:0]     rptr;
  logic [FW:0]       cnt;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;

  // A same-cycle start hands the incoming result a fresh, empty pack register.
  always_comb begin
    lane_eff = cfg_start ? '0 : lane;
    strb_eff = cfg_start ? '0 : {1'b0, strb_acc};
    hit      = mpe_vld_o ? ({{(PACK-1){1'b0}}, 1'b1} << lane_eff) : '0;
    strb_new = strb_eff | hit;
    complete = &strb_new;
    push     = complete | (flush & ~cfg_start & (|strb_new));
  end

  for (genvar i = 0; i < PACK; i++) begin : g_word
    if (i < PACK - 1) begin : g_st
      assign word[i*DATA_W +: DATA_W] =
        !strb_new[i] ? '0 : hit[i] ? mpe_result : lanes[i];
    end else begin : g_top
      assign word[i*DATA_W +: DATA_W] = hit[i] ? mpe_result : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane     <= '0;
      strb_acc <= '0;
      for (int i = 0; i < PACK - 1; i++) lanes[i] <= '0;
    end else begin
      for (int i = 0; i < PACK - 1; i++)
        if (hit[i]) lanes[i] <= mpe_result;
      lane     <= push ? '0 : lane_eff + LW'(mpe_vld_o);
      strb_acc <= push ? '0 : strb_new[PACK-2:0];
    end
  end

  assign empty    = (cnt == '0);
  assign full     = (cnt == (FW+1)'(FIFO_DEPTH));
  assign wb_valid = ~empty;
  assign pop      = wb_valid & wb_ready & ~cfg_start;
  assign push_ok  = push & (~full | pop);
  assign wb_data  = wb_valid ? mem_data[rptr] : '0;
  assign wb_strb  = wb_valid ? mem_strb[rptr] : '0;
  assign busy     = (lane != '0) | ~empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_data[wptr] <= word;
      mem_strb[wptr] <= strb_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      wb_addr  <= '0;
      wb_count <= '0;
    end else if (cfg_start) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      wb_addr  <= cfg_base_addr;
      wb_count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (FW+1)'(push_ok) - (FW+1)'(pop);
      if (push & ~push_ok) overflow <= 1'b1;
      if (pop) begin
        wb_addr <= wb_addr + 1'b1;
        if (wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
      end
    end
  end

endmodule
